// File: rtl/ram_responder_if.sv
// RAM-side request/response bus between the memory controller (master) and the RAM model (slave).
// ramstate encoding: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
interface ram_responder_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM slave answering each request with a fixed LAT-cycle access latency.
// Optional feature macro RAM_ERRCHK_EN: misaligned or out-of-range addresses answer ERROR.
module ram_responder #(
  parameter int LAT    = 2,
  parameter int ADDR_W = 14
) (
  input logic            CLK,
  input logic            nRST,
  ram_responder_if.slave bus
);
  localparam logic [1:0] ST_FREE   = 2'd0;
  localparam logic [1:0] ST_BUSY   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;
  localparam logic [3:0] CNT_RELOAD = 4'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3} state_t;

  state_t            state_r, state_nxt_s;
  logic [3:0]        cnt_r, cnt_nxt_s;
  logic              op_r;
  logic [31:0]       addr_r, store_r, ramload_r;
  logic [31:0]       mem_r [2**ADDR_W];
  logic              req_valid_s, req_both_s, req_bad_s, req_changed_s;
  logic              latch_s, load_en_s, rd_op_s;
  logic [ADDR_W-1:0] req_idx_s, lat_idx_s, rd_idx_s;
  logic [31:0]       rd_data_s;

  assign req_valid_s   = bus.ramREN ^ bus.ramWEN;
  assign req_both_s    = bus.ramREN & bus.ramWEN;
  assign req_changed_s = (bus.ramWEN != op_r) || (bus.ramaddr != addr_r) || (bus.ramstore != store_r);
  assign req_idx_s     = bus.ramaddr[ADDR_W+1:2];
  assign lat_idx_s     = addr_r[ADDR_W+1:2];

`ifdef RAM_ERRCHK_EN
  assign req_bad_s = (bus.ramaddr[1:0] != 2'b00) ||
                     (bus.ramaddr[31:ADDR_W+2] != {(30-ADDR_W){1'b0}});
`else
  assign req_bad_s = 1'b0;
`endif

  // Next-state logic: accept, restart, abort and latency countdown.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    case (state_r)
      S_IDLE, S_ACC: begin
        if (req_both_s) begin
          state_nxt_s = S_ERR;
        end else if (req_valid_s) begin
          latch_s   = 1'b1;
          cnt_nxt_s = CNT_RELOAD;
          if (req_bad_s) begin
            state_nxt_s = S_ERR;
          end else if (LAT > 1) begin
            state_nxt_s = S_WAIT;
          end else begin
            state_nxt_s = S_ACC;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (req_both_s) begin
          state_nxt_s = S_ERR;
        end else if (!req_valid_s) begin
          state_nxt_s = S_IDLE;
        end else if (req_changed_s) begin
          // Restart: the new request gets the full latency from this cycle on.
          latch_s     = 1'b1;
          cnt_nxt_s   = CNT_RELOAD;
          state_nxt_s = req_bad_s ? S_ERR : S_WAIT;
        end else if (cnt_r == 4'd1) begin
          state_nxt_s = S_ACC;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      S_ERR:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Read path for the request entering ACC; forwards a write retiring in this same cycle.
  always_comb begin
    rd_idx_s  = latch_s ? req_idx_s : lat_idx_s;
    rd_op_s   = latch_s ? bus.ramWEN : op_r;
    load_en_s = (state_nxt_s == S_ACC) && !rd_op_s;
    if ((state_r == S_ACC) && op_r && (lat_idx_s == rd_idx_s)) begin
      rd_data_s = store_r;
    end else begin
      rd_data_s = mem_r[rd_idx_s];
    end
  end

  // State, countdown, latched request and read-data registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= S_IDLE;
      cnt_r     <= 4'd0;
      op_r      <= 1'b0;
      addr_r    <= 32'd0;
      store_r   <= 32'd0;
      ramload_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        op_r    <= bus.ramWEN;
        addr_r  <= bus.ramaddr;
        store_r <= bus.ramstore;
      end
      if (load_en_s) begin
        ramload_r <= rd_data_s;
      end
    end
  end

  // Memory array: written only at the end of a write ACC cycle, never reset.
  always_ff @(posedge CLK) begin
    if ((state_r == S_ACC) && op_r) begin
      mem_r[lat_idx_s] <= store_r;
    end
  end

  // Output decode from the registered state only.
  always_comb begin
    bus.ramload = ramload_r;
    case (state_r)
      S_IDLE:  bus.ramstate = ST_FREE;
      S_WAIT:  bus.ramstate = ST_BUSY;
      S_ACC:   bus.ramstate = ST_ACCESS;
      S_ERR:   bus.ramstate = ST_ERROR;
      default: bus.ramstate = ST_FREE;
    endcase
  end
endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: cycle-by-cycle comparison against a latency/memory model
// plus hand-computed literal expectations for each scenario.
module tb_ram_responder;
  localparam int LAT    = 2;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  ram_responder_if bus ();

  ram_responder #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Model: expected outputs plus the request currently being served.
  logic [1:0]  m_state = FREE;
  logic [31:0] m_load = 32'd0;
  bit          m_load_known = 1'b0;
  int          m_start = 0;
  bit          m_op = 1'b0;
  logic [31:0] m_addr = 32'd0, m_store = 32'd0;
  logic [31:0] m_mem [DEPTH];
  bit          m_written [DEPTH];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  function automatic bit bad_addr(input logic [31:0] a);
`ifdef RAM_ERRCHK_EN
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [1:0] after_new(input logic [31:0] a);
    if (bad_addr(a)) return ERROR;
    return (LAT <= 1) ? ACCESS : BUSY;
  endfunction

  // Memory content seen by a read that starts now, including a write finishing this edge.
  function automatic logic [31:0] read_now(input logic [31:0] a);
    if (m_state == ACCESS && m_op && idx_of(m_addr) == idx_of(a)) return m_store;
    return m_mem[idx_of(a)];
  endfunction

  function automatic bit known_now(input logic [31:0] a);
    if (m_state == ACCESS && m_op && idx_of(m_addr) == idx_of(a)) return 1'b1;
    return m_written[idx_of(a)];
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_state      <= FREE;
      m_load       <= 32'd0;
      m_load_known <= 1'b1;
    end else begin
      if (m_state == ACCESS && m_op) begin
        m_mem[idx_of(m_addr)]     <= m_store;
        m_written[idx_of(m_addr)] <= 1'b1;
      end
      if (m_state == ERROR) begin
        m_state <= FREE;
      end else if (bus.ramREN && bus.ramWEN) begin
        m_state <= ERROR;
      end else if (m_state == BUSY && !bus.ramREN && !bus.ramWEN) begin
        m_state <= FREE;
      end else if ((m_state != BUSY && (bus.ramREN ^ bus.ramWEN)) ||
                   (m_state == BUSY && (bus.ramWEN != m_op || bus.ramaddr != m_addr ||
                                        bus.ramstore != m_store))) begin
        m_start <= cyc;
        m_op    <= bus.ramWEN;
        m_addr  <= bus.ramaddr;
        m_store <= bus.ramstore;
        m_state <= after_new(bus.ramaddr);
        if (after_new(bus.ramaddr) == ACCESS && !bus.ramWEN) begin
          m_load       <= read_now(bus.ramaddr);
          m_load_known <= known_now(bus.ramaddr);
        end
      end else if (m_state == BUSY) begin
        if (cyc + 1 - m_start >= LAT) begin
          m_state <= ACCESS;
          if (!m_op) begin
            m_load       <= read_now(m_addr);
            m_load_known <= known_now(m_addr);
          end
        end
      end else begin
        m_state <= FREE;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        check("model_state", 32'(bus.ramstate), 32'(m_state));
        if (m_load_known) check("model_load", bus.ramload, m_load);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic drive(input bit ren, input bit wen, input logic [31:0] a, input logic [31:0] d);
    bus.ramREN   = ren;
    bus.ramWEN   = wen;
    bus.ramaddr  = a;
    bus.ramstore = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  // Present a request now and return in its ACCESS cycle; lat = cycles waited.
  task automatic do_req(input bit ren, input bit wen, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
    lat = -1;
    drive(ren, wen, a, d);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.ramstate == ACCESS) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("access_timeout", 32'(bus.ramstate), 32'(ACCESS));
  endtask

  initial begin
    int lat;
    idle();
    nRST = 1'b0;
    repeat (3) step();
    check("reset_state", 32'(bus.ramstate), 32'(FREE));
    check("reset_load", bus.ramload, 32'd0);
    chk_en = 1'b1;
    nRST   = 1'b1;

    // 1: write then read with the stated cycle timing
    drive(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF);
    step(); check("t1_w_busy_c1", 32'(bus.ramstate), 32'(BUSY));
    step(); check("t1_w_access_c2", 32'(bus.ramstate), 32'(ACCESS));
    idle();
    step(); drive(1'b1, 1'b0, 32'h40, 32'd0);
    step(); check("t1_r_busy_c4", 32'(bus.ramstate), 32'(BUSY));
    step(); check("t1_r_access_c5", 32'(bus.ramstate), 32'(ACCESS));
    check("t1_r_load", bus.ramload, 32'hDEAD_BEEF);
    idle();
    step(); check("t1_load_hold", bus.ramload, 32'hDEAD_BEEF);

    // 2: back-to-back reads issued in the ACCESS cycle
    do_req(1'b0, 1'b1, 32'h100, 32'h1111_1111, lat);
    do_req(1'b0, 1'b1, 32'h104, 32'h2222_2222, lat);
    check("t2_wb2b_lat", 32'(lat), 32'(LAT));
    idle(); step();
    do_req(1'b1, 1'b0, 32'h100, 32'd0, lat);
    check("t2_load0", bus.ramload, 32'h1111_1111);
    do_req(1'b1, 1'b0, 32'h104, 32'd0, lat);
    check("t2_b2b_lat", 32'(lat), 32'(LAT));
    check("t2_load1", bus.ramload, 32'h2222_2222);
    idle(); step();

    // 3: address change while BUSY restarts the latency
    do_req(1'b0, 1'b1, 32'h200, 32'h3333_3333, lat);
    do_req(1'b0, 1'b1, 32'h300, 32'h4444_4444, lat);
    idle(); step();
    drive(1'b1, 1'b0, 32'h200, 32'd0);
    step(); check("t3_busy", 32'(bus.ramstate), 32'(BUSY));
    do_req(1'b1, 1'b0, 32'h300, 32'd0, lat);
    check("t3_restart_lat", 32'(lat), 32'(LAT));
    check("t3_load", bus.ramload, 32'h4444_4444);
    idle(); step();

    // 4: aborted write and reset during BUSY leave memory untouched
    do_req(1'b0, 1'b1, 32'h80, 32'hA5A5_A5A5, lat);
    idle(); step();
    drive(1'b0, 1'b1, 32'h80, 32'h0000_1234);
    step(); check("t4_busy", 32'(bus.ramstate), 32'(BUSY));
    idle();
    step(); check("t4_abort_free", 32'(bus.ramstate), 32'(FREE));
    do_req(1'b1, 1'b0, 32'h80, 32'd0, lat);
    check("t4_abort_nowrite", bus.ramload, 32'hA5A5_A5A5);
    idle(); step();
    drive(1'b0, 1'b1, 32'h80, 32'h0000_1234);
    step(); check("t4_busy2", 32'(bus.ramstate), 32'(BUSY));
    nRST = 1'b0;
    idle();
    #1;
    check("t4_rst_free", 32'(bus.ramstate), 32'(FREE));
    check("t4_rst_load", bus.ramload, 32'd0);
    step();
    nRST = 1'b1;
    step();
    do_req(1'b1, 1'b0, 32'h80, 32'd0, lat);
    check("t4_rst_nowrite", bus.ramload, 32'hA5A5_A5A5);
    idle(); step();

    // 5: REN and WEN together
    drive(1'b1, 1'b1, 32'h40, 32'hFFFF_FFFF);
    step(); check("t5_error", 32'(bus.ramstate), 32'(ERROR));
    idle();
    step(); check("t5_free", 32'(bus.ramstate), 32'(FREE));
    do_req(1'b1, 1'b0, 32'h40, 32'd0, lat);
    check("t5_mem_kept", bus.ramload, 32'hDEAD_BEEF);
    idle(); step();

    // 6: unaligned and out-of-range addresses
`ifdef RAM_ERRCHK_EN
    drive(1'b1, 1'b0, 32'h41, 32'd0);
    step(); check("t6_unaligned_err", 32'(bus.ramstate), 32'(ERROR));
    idle();
    step(); check("t6_err_free", 32'(bus.ramstate), 32'(FREE));
    check("t6_err_load_kept", bus.ramload, 32'hDEAD_BEEF);
    drive(1'b1, 1'b0, 32'h1_0040, 32'd0);
    step(); check("t6_range_err", 32'(bus.ramstate), 32'(ERROR));
    idle(); step();
`else
    do_req(1'b1, 1'b0, 32'h104, 32'd0, lat);
    idle(); step();
    do_req(1'b1, 1'b0, 32'h41, 32'd0, lat);
    check("t6_unaligned_load", bus.ramload, 32'hDEAD_BEEF);
    idle(); step();
    do_req(1'b1, 1'b0, 32'h104, 32'd0, lat);
    idle(); step();
    do_req(1'b1, 1'b0, 32'h1_0040, 32'd0, lat);
    check("t6_alias_load", bus.ramload, 32'hDEAD_BEEF);
    idle(); step();
`endif

    // Read right after a write to the same word sees the new data; writes leave ramload alone
    do_req(1'b0, 1'b1, 32'h40, 32'h5A5A_0001, lat);
    check("t7_write_keeps_load", bus.ramload, 32'hDEAD_BEEF);
    do_req(1'b1, 1'b0, 32'h40, 32'd0, lat);
    check("t7_rdw_load", bus.ramload, 32'h5A5A_0001);
    idle();
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
